// File: rtl/cache_pkg.sv
// cache_pkg: definitions shared by the line-memory controller and its storage.
//   - C2 bus command encodings
//   - line geometry (tag/set/offset widths, bytes per line, beat width)
//   - controller state enumeration
package cache_pkg;

    localparam int unsigned TAG_W       = 10;
    localparam int unsigned SET_W       = 5;
    localparam int unsigned OFFSET_W    = 4;
    localparam int unsigned LINE_ADDR_W = TAG_W + SET_W;
    localparam int unsigned LINE_BYTES  = 1 << OFFSET_W;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BEAT_BYTES  = DATA_W / 8;
    localparam int unsigned BEAT_W      = 3;

    typedef enum logic [1:0] {
        CMD_NOP        = 2'd0,
        CMD_RESPONSE   = 2'd1,
        CMD_READ_LINE  = 2'd2,
        CMD_WRITE_LINE = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_RX,
        WAIT,
        RD_TX,
        WR_ACK
    } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array: byte storage for the line memory, organised as two byte banks
// (even and odd byte of each 16-bit beat).
// Ports:
//   clk      clock
//   we       write enable for one beat
//   wr_line  line address of the write
//   wr_beat  beat index within the line (bytes 2k, 2k+1)
//   wr_data  beat data {byte 2k+1, byte 2k}
//   rd_line  line address of the read
//   rd_beat  beat index of the read
//   rd_data  asynchronous read data {byte 2k+1, byte 2k}
// Contents start at zero and are never cleared.
module mem_array #(
    parameter int unsigned LINE_BYTES = cache_pkg::LINE_BYTES
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [cache_pkg::LINE_ADDR_W-1:0]  wr_line,
    input  logic [cache_pkg::BEAT_W-1:0]       wr_beat,
    input  logic [cache_pkg::DATA_W-1:0]       wr_data,
    input  logic [cache_pkg::LINE_ADDR_W-1:0]  rd_line,
    input  logic [cache_pkg::BEAT_W-1:0]       rd_beat,
    output logic [cache_pkg::DATA_W-1:0]       rd_data
);
    import cache_pkg::*;

    localparam int unsigned BEATS = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned WORDS = BEATS << LINE_ADDR_W;
    localparam int unsigned WA_W  = LINE_ADDR_W + BEAT_W;

    logic [7:0] lo_bank [WORDS] = '{default: '0};
    logic [7:0] hi_bank [WORDS] = '{default: '0};

    logic [WA_W-1:0] wa;
    logic [WA_W-1:0] ra;

    assign wa = {wr_line, wr_beat};
    assign ra = {rd_line, rd_beat};

    always_ff @(posedge clk) begin
        if (we) begin
            lo_bank[wa] <= wr_data[7:0];
            hi_bank[wa] <= wr_data[15:8];
        end
    end

    assign rd_data = {hi_bank[ra], lo_bank[ra]};

endmodule

// File: rtl/mem_ctr.sv
// mem_ctr: bus-side controller of a line memory with fixed access latency.
// Ports:
//   clk    clock, all state changes on the rising edge
//   RESET  synchronous active-high reset
//   A2     line address {tag, set}, sampled with the command
//   C2     bidirectional command bus; driven with RESPONSE only while answering
//   D2     bidirectional data bus; driven only during read beats
//   busy   high from command acceptance until the last response cycle
// Parameters:
//   MEM_LATENCY  edges from read acceptance to first response beat
//   LINE_BYTES   bytes per line, moved as 16-bit beats
module mem_ctr #(
    parameter int unsigned MEM_LATENCY = 100,
    parameter int unsigned LINE_BYTES  = cache_pkg::LINE_BYTES
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [14:0]      A2,
    inout  wire logic [1:0]  C2,
    inout  wire logic [15:0] D2,
    output logic             busy
);
    import cache_pkg::*;

    localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES / BEAT_BYTES - 1);

    state_e                   state_q, state_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [LINE_ADDR_W-1:0]   line_q, line_d;
    logic                     wr_op_q, wr_op_d;

    logic                     mem_we;
    logic [LINE_ADDR_W-1:0]   mem_wline;
    logic [BEAT_W-1:0]        mem_wbeat;
    logic [DATA_W-1:0]        rd_data;
    logic                     drive_c;
    logic                     drive_d;

    mem_array #(
        .LINE_BYTES (LINE_BYTES)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_line (mem_wline),
        .wr_beat (mem_wbeat),
        .wr_data (D2),
        .rd_line (line_q),
        .rd_beat (beat_q),
        .rd_data (rd_data)
    );

    // Bus enables depend only on registered state so the command decode in
    // IDLE never sees its own drivers in a combinational path.
    assign drive_c = (state_q == RD_TX) || (state_q == WR_ACK);
    assign drive_d = (state_q == RD_TX);
    assign busy    = (state_q != IDLE);

    assign C2 = drive_c ? 2'(CMD_RESPONSE) : 'z;
    assign D2 = drive_d ? rd_data : 'z;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        line_d    = line_q;
        wr_op_d   = wr_op_q;
        mem_we    = 1'b0;
        mem_wline = line_q;
        mem_wbeat = beat_q;

        case (state_q)
            IDLE: begin
                if (C2 == CMD_READ_LINE) begin
                    line_d  = A2;
                    wr_op_d = 1'b0;
                    lat_d   = LAT_LOAD;
                    beat_d  = '0;
                    state_d = WAIT;
                end else if (C2 == CMD_WRITE_LINE) begin
                    // Beat 0 travels with the command, so it is stored
                    // straight from A2 before the address is latched.
                    line_d    = A2;
                    wr_op_d   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wline = A2;
                    mem_wbeat = '0;
                    beat_d    = BEAT_W'(1);
                    state_d   = WR_RX;
                end
            end
            WR_RX: begin
                mem_we = 1'b1;
                if (beat_q == LAST_BEAT) begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    beat_d  = '0;
                    state_d = wr_op_q ? WR_ACK : RD_TX;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RD_TX: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A beat or command arriving on a reset edge is discarded.
        if (RESET) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            wr_op_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            wr_op_q <= wr_op_d;
        end
    end

endmodule

// File: tb/tb_mem_ctr.sv
module tb_mem_ctr;

    localparam int LAT = 100;

    typedef struct {
        logic        is_ack;
        logic        last;
        logic [15:0] data;
        int          cyc;
        int          idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             RESET;
    logic [14:0]      A2;
    logic [14:0]      A2_1;
    wire logic [1:0]  C2;
    wire logic [15:0] D2;
    wire logic [1:0]  C2_1;
    wire logic [15:0] D2_1;
    logic             busy;
    logic             busy_1;

    logic [1:0]  tb_c;
    logic        tb_c_en;
    logic [15:0] tb_d;
    logic        tb_d_en;
    logic [1:0]  tb_c1;
    logic        tb_c1_en;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t e;
    logic rel_pending = 1'b0;

    assign C2   = tb_c_en  ? tb_c  : 'z;
    assign D2   = tb_d_en  ? tb_d  : 'z;
    assign C2_1 = tb_c1_en ? tb_c1 : 'z;

    // Released bus reads NOP on C2 and all-ones on D2.
    for (genvar i = 0; i < 16; i++) begin : g_pull_d
        pullup (D2[i]);
        pullup (D2_1[i]);
    end
    for (genvar i = 0; i < 2; i++) begin : g_pull_c
        pulldown (C2[i]);
        pulldown (C2_1[i]);
    end

    mem_ctr #(.MEM_LATENCY(LAT), .LINE_BYTES(16)) u_dut (
        .clk   (clk),
        .RESET (RESET),
        .A2    (A2),
        .C2    (C2),
        .D2    (D2),
        .busy  (busy)
    );

    mem_ctr #(.MEM_LATENCY(1), .LINE_BYTES(16)) u_dut1 (
        .clk   (clk),
        .RESET (RESET),
        .A2    (A2_1),
        .C2    (C2_1),
        .D2    (D2_1),
        .busy  (busy_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: pops one expectation per RESPONSE cycle seen on the bus.
    always @(negedge clk) begin
        if (rel_pending && !tb_c_en && !tb_d_en) begin
            rel_pending = 1'b0;
            chk("release_c2", 32'(C2), 32'd0);
            chk("release_d2", 32'(D2), 32'hFFFF);
            chk("release_busy", 32'(busy), 32'd0);
        end
        if (!tb_c_en && C2 == 2'd1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response cyc=%0d got C2=1 D2=%0h expected none", cyc, D2);
            end else begin
                e = sb.pop_front();
                if (e.is_ack) begin
                    chk("ack_d2_z", 32'(D2), 32'hFFFF);
                end else begin
                    chk($sformatf("beat%0d_data", e.idx), 32'(D2), 32'(e.data));
                end
                if (e.cyc >= 0) chk($sformatf("beat%0d_cycle", e.idx), 32'(cyc), 32'(e.cyc));
                chk("busy_during_resp", 32'(busy), 32'd1);
                if (e.last) rel_pending = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_line(input logic [14:0] a, input logic [15:0] d [8], input int upto);
        int acc;
        acc = cyc + 1;
        for (int k = 0; k <= upto; k++)
            sb.push_back('{is_ack: 1'b0, last: (k == upto), data: d[k], cyc: acc + LAT + k, idx: k});
        tb_c = 2'd2; A2 = a; tb_c_en = 1'b1;
        step();
        tb_c_en = 1'b0;
    endtask

    task automatic write_line(input logic [14:0] a, input logic [15:0] d [8],
                              input int rst_at, input logic push_ack);
        tb_c = 2'd3; A2 = a; tb_d = d[0]; tb_c_en = 1'b1; tb_d_en = 1'b1;
        step();
        tb_c_en = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tb_d = d[k];
            if (k == rst_at) RESET = 1'b1;
            step();
            if (k == rst_at) begin
                RESET = 1'b0;
                break;
            end
        end
        tb_d_en = 1'b0;
        if (push_ack) sb.push_back('{is_ack: 1'b1, last: 1'b1, data: 16'hFFFF, cyc: -1, idx: 0});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
        step();
        step();
    endtask

    logic [15:0] zeros [8];
    logic [15:0] pat   [8];
    logic [15:0] junk  [8];
    logic [15:0] oldp  [8];
    logic [15:0] newp  [8];
    logic [15:0] mixed [8];

    initial begin
        for (int k = 0; k < 8; k++) begin
            zeros[k] = 16'h0000;
            pat[k]   = {8'(2 * k + 1), 8'(2 * k)};
            junk[k]  = 16'hAA50 + 16'(k);
            oldp[k]  = 16'hA000 + 16'(k);
            newp[k]  = 16'hB000 + 16'(k);
            mixed[k] = (k <= 4) ? newp[k] : oldp[k];
        end
        RESET = 1'b1; A2 = '0; A2_1 = '0;
        tb_c = '0; tb_c_en = 1'b0; tb_d = '0; tb_d_en = 1'b0;
        tb_c1 = '0; tb_c1_en = 1'b0;
        repeat (3) step();
        RESET = 1'b0;

        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_c2", 32'(C2), 32'd0);
        chk("reset_d2", 32'(D2), 32'hFFFF);
        chk("reset_busy_lat1", 32'(busy_1), 32'd0);
        chk("reset_d2_lat1", 32'(D2_1), 32'hFFFF);
        step();

        // Read of zeroed line, first beat exactly LAT edges after acceptance.
        read_line(15'h0001, zeros, 7);
        repeat (10) step();
        chk("busy_in_wait", 32'(busy), 32'd1);
        drain(200);
        chk("idle_after_read", 32'(busy), 32'd0);

        // Full write then read back.
        write_line(15'h7FFF, pat, 8, 1'b1);
        drain(200);
        chk("idle_after_write", 32'(busy), 32'd0);
        read_line(15'h7FFF, pat, 7);
        drain(200);

        // RESPONSE and NOP on the bus in IDLE are ignored.
        tb_c = 2'd1; tb_c_en = 1'b1;
        step();
        chk("ignore_response", 32'(busy), 32'd0);
        tb_c = 2'd0;
        step();
        chk("ignore_nop", 32'(busy), 32'd0);
        tb_c_en = 1'b0;

        // Command coinciding with reset is discarded.
        RESET = 1'b1; tb_c = 2'd2; A2 = 15'h0001; tb_c_en = 1'b1;
        step();
        RESET = 1'b0; tb_c_en = 1'b0;
        chk("cmd_with_reset", 32'(busy), 32'd0);
        repeat (LAT + 10) step();
        chk("cmd_with_reset_late", 32'(busy), 32'd0);

        // Write issued 5 cycles into a read is ignored.
        read_line(15'h7FFF, pat, 7);
        repeat (4) step();
        write_line(15'h7FFF, junk, 8, 1'b0);
        drain(200);
        read_line(15'h7FFF, pat, 7);
        drain(200);

        // Reset after write beat 4: beats 0..4 new, 5..7 old.
        write_line(15'h0123, oldp, 8, 1'b1);
        drain(200);
        write_line(15'h0123, newp, 5, 1'b0);
        chk("busy_after_wr_reset", 32'(busy), 32'd0);
        read_line(15'h0123, mixed, 7);
        drain(200);

        // Reset during read beat 3, then a normal read.
        begin
            int tgt;
            tgt = cyc + 1 + LAT + 3;
            read_line(15'h0123, mixed, 3);
            while (cyc < tgt) step();
            RESET = 1'b1;
            step();
            RESET = 1'b0;
            chk("busy_after_rd_reset", 32'(busy), 32'd0);
            drain(20);
        end
        read_line(15'h7FFF, pat, 7);
        drain(200);

        // Latency-1 build: beat 0 on the cycle after acceptance.
        tb_c1 = 2'd2; A2_1 = 15'h0005; tb_c1_en = 1'b1;
        step();
        tb_c1_en = 1'b0;
        @(negedge clk);
        chk("lat1_wait_c2", 32'(C2_1), 32'd0);
        chk("lat1_busy", 32'(busy_1), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("lat1_beat%0d_c2", k), 32'(C2_1), 32'd1);
            chk($sformatf("lat1_beat%0d_d2", k), 32'(D2_1), 32'd0);
        end
        @(negedge clk);
        chk("lat1_release_c2", 32'(C2_1), 32'd0);
        chk("lat1_release_d2", 32'(D2_1), 32'hFFFF);
        chk("lat1_idle", 32'(busy_1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
